// File: rtl/approx_err_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// The LFSR step is the right-shifting Galois form of x^32+x^22+x^2+x+1.
package approx_err_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam int          LAT_MAX   = 7;
   localparam int          DRAIN_W   = $clog2(LAT_MAX + 1);

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/lfsr32_gen.sv
// 32-bit Galois LFSR with synchronous seed load; a zero seed becomes 1 so
// the register can never lock up.
module lfsr32_gen
   import approx_err_pkg::*;
#(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      seed,
   input  logic             load,
   input  logic             step,
   output logic [OUT_W-1:0] q
);

   logic [31:0] seed_nz;
   logic [31:0] state_q;

   assign seed_nz = (seed == 32'h0) ? 32'h1 : seed;

   always_ff @(posedge clk) begin
      if (rst || load)
         state_q <= seed_nz;
      else if (step)
         state_q <= lfsr_next(state_q);
   end

   assign q = state_q[OUT_W-1:0];

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Drives pseudo-random operands into an approximate adder, realigns the exact
// sum with the returned sum and accumulates raw error statistics.
module approx_adder_error_monitor
   import approx_err_pkg::*;
#(
   parameter int          N      = 16,
   parameter int          CNT_W  = 32,
   parameter int          ACC_W  = 48,
   parameter int          LAT    = 0,
   parameter logic [31:0] SEED_A = 32'h1,
   parameter logic [31:0] SEED_B = 32'h2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_tests,
   output logic [N-1:0]     op_a,
   output logic [N-1:0]     op_b,
   input  logic [N-1:0]     dut_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [N-1:0]     max_ed,
   output logic [CNT_W-1:0] zero_count
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   num_q, cnt_q;
   logic [DRAIN_W-1:0] drain_q;
   logic [N-1:0]       hold_a_q, hold_b_q;
   logic [N-1:0]       lfsr_a, lfsr_b;
   logic               launch, iss_vld;
   logic [N-1:0]       exact;
   logic               al_vld;
   logic [N-1:0]       al_ex;
   logic [N-1:0]       ed;
   logic [ACC_W:0]     sum_ext;
   logic [CNT_W-1:0]   err_q, zero_q;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [N-1:0]       max_q;

   lfsr32_gen #(.OUT_W(N)) u_lfsr_a (
      .clk(clk), .rst(rst), .seed(SEED_A), .load(launch), .step(iss_vld), .q(lfsr_a)
   );
   lfsr32_gen #(.OUT_W(N)) u_lfsr_b (
      .clk(clk), .rst(rst), .seed(SEED_B), .load(launch), .step(iss_vld), .q(lfsr_b)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               launch  = 1'b1;
               state_d = (num_tests == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == num_q - CNT_W'(1))
               state_d = (LAT == 0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_W'(LAT - 1))
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign iss_vld = (state_q == S_RUN);
   assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done    = (state_q == S_DONE);

   // Outside RUN the operands freeze on the last issued pair.
   assign op_a  = iss_vld ? lfsr_a : hold_a_q;
   assign op_b  = iss_vld ? lfsr_b : hold_b_q;
   assign exact = op_a + op_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         num_q    <= '0;
         cnt_q    <= '0;
         drain_q  <= '0;
         hold_a_q <= '0;
         hold_b_q <= '0;
      end else begin
         if (launch) begin
            num_q <= num_tests;
            cnt_q <= '0;
         end
         if (iss_vld) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            hold_a_q <= lfsr_a;
            hold_b_q <= lfsr_b;
         end
         drain_q <= (state_q == S_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
      end
   end

   // Exact sum travels LAT stages so it meets the DUT's answer for the same pair.
   if (LAT == 0) begin : g_nopipe
      assign al_vld = iss_vld;
      assign al_ex  = exact;
   end else begin : g_pipe
      logic [LAT-1:0]        vld_pipe_q;
      logic [LAT-1:0][N-1:0] ex_pipe_q;

      always_ff @(posedge clk) begin
         if (rst || launch) begin
            vld_pipe_q <= '0;
         end else begin
            vld_pipe_q[0] <= iss_vld;
            for (int i = 1; i < LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         ex_pipe_q[0] <= exact;
         for (int i = 1; i < LAT; i++) ex_pipe_q[i] <= ex_pipe_q[i-1];
      end

      assign al_vld = vld_pipe_q[LAT-1];
      assign al_ex  = ex_pipe_q[LAT-1];
   end

   assign ed      = (dut_sum > al_ex) ? dut_sum - al_ex : al_ex - dut_sum;
   assign sum_ext = {1'b0, sum_q} + (ACC_W+1)'(ed);
   assign sum_d   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];

   always_ff @(posedge clk) begin
      if (rst || launch) begin
         err_q  <= '0;
         zero_q <= '0;
         sum_q  <= '0;
         max_q  <= '0;
      end else if (al_vld) begin
         err_q  <= err_q + CNT_W'(ed != '0);
         zero_q <= zero_q + CNT_W'(al_ex == '0);
         sum_q  <= sum_d;
         if (ed > max_q) max_q <= ed;
      end
   end

   assign err_count  = err_q;
   assign zero_count = zero_q;
   assign sum_ed     = sum_q;
   assign max_ed     = max_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Three monitor instances (LAT=0, LAT=3, ACC_W=20) each driving a stub adder;
// results are compared against a sample-by-sample statistics model.
module tb_approx_adder_error_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] num;
   logic        start_v [3];
   int          mode_v  [3];
   logic [15:0] opa_v [3], opb_v [3], med_v [3];
   logic        busy_v [3], done_v [3];
   logic [31:0] err_v [3], zero_v [3];
   logic [47:0] sed_v [3];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   // 0 exact, 1 exact^1, 2 zero, 3 ~exact, 4 lower-part OR adder (K=12)
   function automatic logic [15:0] stub(input int m, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] e;
      logic [3:0]  hi;
      e  = a + b;
      hi = a[15:12] + b[15:12] + {3'b000, a[11] & b[11]};
      case (m)
         1:       return e ^ 16'h0001;
         2:       return 16'h0000;
         3:       return ~e;
         4:       return {hi, a[11:0] | b[11:0]};
         default: return e;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int AW = (g == 2) ? 20 : 48;
      localparam int LT = (g == 1) ? 3 : 0;
      logic [AW-1:0] sed_l;
      logic [15:0]   oa, ob, me, appr, dsum;
      logic          bz, dn;
      logic [31:0]   ec, zc;

      approx_adder_error_monitor #(
         .N(16), .CNT_W(32), .ACC_W(AW), .LAT(LT), .SEED_A(32'h1), .SEED_B(32'h2)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start_v[g]), .num_tests(num),
         .op_a(oa), .op_b(ob), .dut_sum(dsum), .busy(bz), .done(dn),
         .err_count(ec), .sum_ed(sed_l), .max_ed(me), .zero_count(zc)
      );

      assign appr = stub(mode_v[g], oa, ob);
      if (LT == 0) begin : g_comb
         assign dsum = appr;
      end else begin : g_reg
         logic [15:0] d1, d2, d3;
         always_ff @(posedge clk) begin
            d1 <= appr;
            d2 <= d1;
            d3 <= d2;
         end
         assign dsum = d3;
      end

      assign opa_v[g]  = oa;
      assign opb_v[g]  = ob;
      assign busy_v[g] = bz;
      assign done_v[g] = dn;
      assign err_v[g]  = ec;
      assign zero_v[g] = zc;
      assign med_v[g]  = me;
      assign sed_v[g]  = 48'(sed_l);
   end

   // Statistics of n samples taken from the two seeded LFSR streams.
   task automatic model(input int n, input int m, input int aw,
                        output longint e_err, output longint e_sed, output longint e_med,
                        output longint e_zero, output logic [15:0] la, output logic [15:0] lb);
      logic [31:0] sa, sb;
      logic [15:0] a, b;
      longint      ex, ap, ed, sat;
      sa = 32'h1; sb = 32'h2;
      sat = (longint'(1) << aw) - 1;
      e_err = 0; e_sed = 0; e_med = 0; e_zero = 0; la = '0; lb = '0;
      for (int k = 0; k < n; k++) begin
         a  = sa[15:0];
         b  = sb[15:0];
         ex = (longint'(a) + longint'(b)) % 65536;
         ap = longint'(stub(m, a, b));
         ed = (ap > ex) ? ap - ex : ex - ap;
         if (ed != 0) e_err++;
         if (ex == 0) e_zero++;
         e_sed = (e_sed + ed > sat) ? sat : e_sed + ed;
         if (ed > e_med) e_med = ed;
         la = a; lb = b;
         sa = sa[0] ? ((sa >> 1) ^ 32'h8020_0003) : (sa >> 1);
         sb = sb[0] ? ((sb >> 1) ^ 32'h8020_0003) : (sb >> 1);
      end
   endtask

   // Launch a run and watch it cycle by cycle (c = cycles after the start edge).
   task automatic run(input int g, input int n, input int m, input int restart_at,
                      output int dcyc, output int bcyc, output logic [15:0] fa, output logic [15:0] fb);
      int lat;
      lat = (g == 1) ? 3 : 0;
      mode_v[g] = m; num = 32'(n);
      dcyc = -1; bcyc = 0; fa = '0; fb = '0;
      @(negedge clk); start_v[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int c = 1; c <= n + lat + 30; c++) begin
         start_v[g] = (c == restart_at);
         if (c == 1) begin fa = opa_v[g]; fb = opb_v[g]; end
         if (busy_v[g]) bcyc++;
         if (done_v[g]) begin dcyc = c; break; end
         @(negedge clk);
      end
      start_v[g] = 1'b0;
   endtask

   task automatic test_reset();
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({opa_v[g], opb_v[g], busy_v[g], done_v[g]} !== 34'h0) begin
            errors++; $display("FAIL reset_ctl[%0d]: got op_a=%h op_b=%h busy=%b done=%b want all 0", g, opa_v[g], opb_v[g], busy_v[g], done_v[g]);
         end
         checks++;
         if ({err_v[g], sed_v[g], med_v[g], zero_v[g]} !== 128'h0) begin
            errors++; $display("FAIL reset_stats[%0d]: got err=%0d sed=%0d med=%0d zero=%0d want 0", g, err_v[g], sed_v[g], med_v[g], zero_v[g]);
         end
      end
   endtask

   task automatic test_exact();
      int d, b; logic [15:0] fa, fb;
      run(0, 1000, 0, 0, d, b, fa, fb);
      checks++; if (d !== 1001) begin errors++; $display("FAIL exact_done: got cycle %0d want 1001", d); end
      checks++; if (b !== 1000) begin errors++; $display("FAIL exact_busy: got %0d cycles want 1000", b); end
      checks++; if ({fa, fb} !== 32'h0001_0002) begin errors++; $display("FAIL first_ops: got %h %h want 0001 0002", fa, fb); end
      checks++;
      if ({err_v[0], sed_v[0], med_v[0]} !== 96'h0) begin
         errors++; $display("FAIL exact_stats: got err=%0d sed=%0d med=%0d want 0", err_v[0], sed_v[0], med_v[0]);
      end
   endtask

   task automatic test_flip();
      int d, b; logic [15:0] fa, fb, la, lb; longint ee, es, em, ez;
      run(0, 500, 1, 0, d, b, fa, fb);
      model(500, 1, 48, ee, es, em, ez, la, lb);
      checks++; if (err_v[0] !== 32'd500) begin errors++; $display("FAIL flip_err: got %0d want 500", err_v[0]); end
      checks++; if (sed_v[0] !== 48'd500) begin errors++; $display("FAIL flip_sed: got %0d want 500", sed_v[0]); end
      checks++; if (med_v[0] !== 16'd1) begin errors++; $display("FAIL flip_med: got %0d want 1", med_v[0]); end
      checks++; if (zero_v[0] !== 32'(ez)) begin errors++; $display("FAIL flip_zero: got %0d want %0d", zero_v[0], ez); end
      checks++;
      if ({opa_v[0], opb_v[0]} !== {la, lb}) begin
         errors++; $display("FAIL hold_ops: got %h %h want %h %h", opa_v[0], opb_v[0], la, lb);
      end
   endtask

   task automatic test_latency();
      int d, b; logic [15:0] fa, fb;
      run(1, 64, 0, 0, d, b, fa, fb);
      checks++; if (d !== 68) begin errors++; $display("FAIL lat3_done: got cycle %0d want 68", d); end
      checks++; if (b !== 67) begin errors++; $display("FAIL lat3_busy: got %0d cycles want 67", b); end
      checks++;
      if ({err_v[1], sed_v[1], med_v[1]} !== 96'h0) begin
         errors++; $display("FAIL lat3_stats: got err=%0d sed=%0d med=%0d want 0", err_v[1], sed_v[1], med_v[1]);
      end
   endtask

   task automatic test_zero_tests();
      int d, b; logic [15:0] fa, fb, la, lb; longint ee, es, em, ez;
      run(0, 0, 0, 0, d, b, fa, fb);
      checks++; if (d !== 1 || b !== 0) begin errors++; $display("FAIL zero_n: got done@%0d busy=%0d want done@1 busy=0", d, b); end
      checks++;
      if ({err_v[0], sed_v[0], med_v[0], zero_v[0]} !== 128'h0) begin
         errors++; $display("FAIL zero_n_stats: got err=%0d sed=%0d want 0", err_v[0], sed_v[0]);
      end
      run(0, 10, 2, 0, d, b, fa, fb);
      model(10, 2, 48, ee, es, em, ez, la, lb);
      checks++; if (err_v[0] !== 32'd10 - zero_v[0]) begin errors++; $display("FAIL ten_err: got %0d want %0d", err_v[0], 32'd10 - zero_v[0]); end
      checks++;
      if (sed_v[0] !== 48'(es) || zero_v[0] !== 32'(ez)) begin
         errors++; $display("FAIL ten_model: got sed=%0d zero=%0d want %0d %0d", sed_v[0], zero_v[0], es, ez);
      end
   endtask

   task automatic test_reset_midrun();
      int d, b; logic [15:0] fa, fb, la, lb; longint ee, es, em, ez;
      logic [31:0] e1; logic [47:0] s1; logic [15:0] m1;
      mode_v[0] = 4; num = 32'd1000;
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (199) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checks++;
      if ({opa_v[0], opb_v[0], busy_v[0], done_v[0]} !== 34'h0) begin
         errors++; $display("FAIL abort_ctl: got op_a=%h busy=%b done=%b want 0", opa_v[0], busy_v[0], done_v[0]);
      end
      checks++;
      if ({err_v[0], sed_v[0], med_v[0], zero_v[0]} !== 128'h0) begin
         errors++; $display("FAIL abort_stats: got err=%0d sed=%0d want 0", err_v[0], sed_v[0]);
      end
      run(0, 1000, 4, 0, d, b, fa, fb);
      e1 = err_v[0]; s1 = sed_v[0]; m1 = med_v[0];
      run(0, 1000, 4, 100, d, b, fa, fb);
      checks++;
      if ({err_v[0], sed_v[0], med_v[0]} !== {e1, s1, m1}) begin
         errors++; $display("FAIL repro: got %0d %0d %0d want %0d %0d %0d", err_v[0], sed_v[0], med_v[0], e1, s1, m1);
      end
      model(1000, 4, 48, ee, es, em, ez, la, lb);
      checks++;
      if ({err_v[0], sed_v[0], med_v[0], zero_v[0]} !== {32'(ee), 48'(es), 16'(em), 32'(ez)}) begin
         errors++; $display("FAIL approx_model: got %0d %0d %0d %0d want %0d %0d %0d %0d", err_v[0], sed_v[0], med_v[0], zero_v[0], ee, es, em, ez);
      end
      checks++; if (d !== 1001) begin errors++; $display("FAIL restart_ignored: got done@%0d want 1001", d); end
   endtask

   task automatic test_saturation();
      int d, b; logic [15:0] fa, fb, la, lb; longint ee, es, em, ez;
      run(2, 100, 3, 0, d, b, fa, fb);
      model(100, 3, 20, ee, es, em, ez, la, lb);
      checks++; if (sed_v[2] !== 48'hF_FFFF) begin errors++; $display("FAIL sat_sed: got %h want fffff", sed_v[2]); end
      checks++; if (err_v[2] !== 32'd100) begin errors++; $display("FAIL sat_err: got %0d want 100", err_v[2]); end
      checks++; if (med_v[2] !== 16'(em)) begin errors++; $display("FAIL sat_med: got %0d want %0d", med_v[2], em); end
   endtask

   task automatic test_random();
      int d, b, g, n, m, lat; logic [15:0] fa, fb, la, lb; longint ee, es, em, ez;
      for (int r = 0; r < 5; r++) begin
         g = int'($urandom_range(0, 2));
         n = int'($urandom_range(1, 300));
         m = int'($urandom_range(0, 4));
         lat = (g == 1) ? 3 : 0;
         run(g, n, m, 0, d, b, fa, fb);
         model(n, m, (g == 2) ? 20 : 48, ee, es, em, ez, la, lb);
         checks++;
         if ({err_v[g], sed_v[g], med_v[g], zero_v[g]} !== {32'(ee), 48'(es), 16'(em), 32'(ez)}) begin
            errors++; $display("FAIL rand_stats[g%0d n%0d m%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                               g, n, m, err_v[g], sed_v[g], med_v[g], zero_v[g], ee, es, em, ez);
         end
         checks++;
         if (d !== n + lat + 1 || b !== n + lat) begin
            errors++; $display("FAIL rand_timing[g%0d n%0d]: got done@%0d busy=%0d want %0d %0d", g, n, d, b, n + lat + 1, n + lat);
         end
      end
   endtask

   initial begin
      rst = 1'b1; num = '0;
      for (int g = 0; g < 3; g++) begin start_v[g] = 1'b0; mode_v[g] = 0; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_exact();
      test_flip();
      test_latency();
      test_zero_tests();
      test_reset_midrun();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
